// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch buffer with PC steering.
// Fetches one word per cycle into a DEPTH-entry circular queue, holds on
// freeze, and flushes everything on a backend misprediction, re-steering
// the fetch PC to the corrected target.
module fetch_queue #(
    parameter int                 WORD_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [WORD_W-1:0]  RESET_PC = '0
) (
    input  logic                      CLK,
    input  logic                      nRST,
    output logic                      imemREN,
    output logic [WORD_W-1:0]         imemaddr,
    input  logic                      ihit,
    input  logic [WORD_W-1:0]         imemload,
    input  logic [WORD_W-1:0]         pc_prediction,
    input  logic                      misprediction,
    input  logic [WORD_W-1:0]         correct_pc,
    input  logic                      freeze,
    output logic                      instr_valid,
    output logic [WORD_W-1:0]         instr,
    output logic [WORD_W-1:0]         pc,
    input  logic                      deq_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        REDIRECT
    } state_t;

    state_t             state;
    logic [WORD_W-1:0]  fetch_pc;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   occ;

    logic [WORD_W-1:0]  mem_pc    [DEPTH];
    logic [WORD_W-1:0]  mem_instr [DEPTH];

    logic full;
    logic nonempty;
    logic push;
    logic pop;

    // Occupancy flags and the push/pop qualifiers; misprediction blocks both.
    always_comb begin
        full     = (occ == FULL_CNT);
        nonempty = (occ != '0);
        push     = imemREN && ihit;
        pop      = nonempty && deq_ready && !misprediction;
    end

    // Fetch request: only while running with space and no flush/freeze.
    // Reset is folded in so the request is low during reset even though
    // the state register already reads RUN.
    always_comb begin
        imemREN = nRST && (state == RUN) && !full && !freeze && !misprediction;
    end

    // Fetch address is the fetch PC register itself.
    always_comb begin
        imemaddr = fetch_pc;
    end

    // FSM, fetch PC, queue pointers and occupancy; misprediction wins over all.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
        end else if (misprediction) begin
            state    <= REDIRECT;
            fetch_pc <= correct_pc;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
        end else begin
            case (state)
                RUN:      state <= freeze ? HOLD : RUN;
                HOLD:     state <= freeze ? HOLD : RUN;
                REDIRECT: state <= freeze ? HOLD : RUN;
                default:  state <= RUN;
            endcase

            if (push) begin
                fetch_pc <= pc_prediction;
                tail     <= tail + PTR_W'(1);
            end

            if (pop) begin
                head <= head + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Entry storage; contents need no reset because outputs are gated by occupancy.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_pc[tail]    <= fetch_pc;
            mem_instr[tail] <= imemload;
        end
    end

    // Head presentation, forced to zero whenever the queue is empty.
    always_comb begin
        count       = occ;
        instr_valid = nonempty;
        instr       = nonempty ? mem_instr[head] : '0;
        pc          = nonempty ? mem_pc[head]    : '0;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed plus randomized stimulus for fetch_queue,
// checked every cycle against a queue-based reference model.
module tb_fetch_queue;

    localparam int W = 32;
    localparam int D = 4;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          imemREN;
    logic [W-1:0]  imemaddr;
    logic          ihit = 1'b0;
    logic [W-1:0]  imemload = '0;
    logic [W-1:0]  pc_prediction = '0;
    logic          misprediction = 1'b0;
    logic [W-1:0]  correct_pc = '0;
    logic          freeze = 1'b0;
    logic          instr_valid;
    logic [W-1:0]  instr;
    logic [W-1:0]  pc;
    logic          deq_ready = 1'b0;
    logic [2:0]    count;

    fetch_queue #(
        .WORD_W  (W),
        .DEPTH   (D),
        .RESET_PC(32'h0)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .imemREN      (imemREN),
        .imemaddr     (imemaddr),
        .ihit         (ihit),
        .imemload     (imemload),
        .pc_prediction(pc_prediction),
        .misprediction(misprediction),
        .correct_pc   (correct_pc),
        .freeze       (freeze),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .pc           (pc),
        .deq_ready    (deq_ready),
        .count        (count)
    );

    always #5 CLK = ~CLK;

    // Reference model: queue contents, fetch PC, and whether fetching is
    // allowed this cycle (only if the previous cycle had neither a flush
    // nor a freeze).
    logic [W-1:0] qpc[$];
    logic [W-1:0] qins[$];
    logic [W-1:0] m_pc;
    bit           m_run;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qpc.delete();
        qins.delete();
        m_pc  = 32'h0;
        m_run = 1'b1;
    endtask

    // Drive one cycle of inputs, compare all outputs with the model before
    // the edge, then advance the model and the clock.
    task automatic step(input bit h, input bit d, input bit mp, input bit fz,
                        input logic [W-1:0] ld, input logic [W-1:0] pred,
                        input logic [W-1:0] cpc);
        bit e_ren;
        ihit          = h;
        deq_ready     = d;
        misprediction = mp;
        freeze        = fz;
        imemload      = ld;
        pc_prediction = pred;
        correct_pc    = cpc;
        #1;
        e_ren = m_run && (qpc.size() < D) && !fz && !mp;
        chk("count",       64'(count),       64'(qpc.size()));
        chk("instr_valid", 64'(instr_valid), 64'(qpc.size() != 0));
        chk("head_pc",     64'(pc),          qpc.size() != 0 ? 64'(qpc[0])  : 64'h0);
        chk("head_instr",  64'(instr),       qins.size() != 0 ? 64'(qins[0]) : 64'h0);
        chk("imemREN",     64'(imemREN),     64'(e_ren));
        chk("imemaddr",    64'(imemaddr),    64'(m_pc));
        if (mp) begin
            qpc.delete();
            qins.delete();
            m_pc = cpc;
        end else begin
            if (qpc.size() != 0 && d) begin
                void'(qpc.pop_front());
                void'(qins.pop_front());
            end
            if (e_ren && h) begin
                qpc.push_back(m_pc);
                qins.push_back(ld);
                m_pc = pred;
            end
        end
        m_run = !mp && !fz;
        @(posedge CLK);
        #1;
    endtask

    // Assert reset between edges, check the asynchronous effect, release on a negedge.
    task automatic async_reset();
        #2;
        nRST = 1'b0;
        #1;
        chk("rst_count",    64'(count),       64'h0);
        chk("rst_valid",    64'(instr_valid), 64'h0);
        chk("rst_instr",    64'(instr),       64'h0);
        chk("rst_pc",       64'(pc),          64'h0);
        chk("rst_imemREN",  64'(imemREN),     64'h0);
        chk("rst_imemaddr", 64'(imemaddr),    64'h0);
        model_reset();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] exp_pc;
        model_reset();

        // Power-on reset and first request
        @(posedge CLK);
        #1;
        async_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, m_pc + 4, '0);
        chk("start_count", 64'(count), 64'h0);

        // Fill the queue from 0x0
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, m_pc + 4, '0);
        chk("fill_count",    64'(count),    64'h4);
        chk("fill_imemaddr", 64'(imemaddr), 64'h10);
        chk("fill_head",     64'(pc),       64'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, m_pc + 4, '0);
        chk("full_hold_cnt", 64'(count),    64'h4);

        // Streaming with wrap: head PCs must march 0x0..0x24
        exp_pc = 32'h0;
        for (int i = 0; i < 10; i++) begin
            chk("stream_pc", 64'(pc), 64'(exp_pc));
            exp_pc = exp_pc + 32'h4;
            step(1'b1, 1'b1, 1'b0, 1'b0, $urandom, m_pc + 4, '0);
        end
        chk("stream_count", 64'(count), 64'h3);

        // Flush with a coincident ihit
        step(1'b1, 1'b1, 1'b1, 1'b0, $urandom, m_pc + 4, 32'h100);
        chk("flush_count", 64'(count),       64'h0);
        chk("flush_valid", 64'(instr_valid), 64'h0);
        chk("flush_addr",  64'(imemaddr),    64'h100);
        step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, m_pc + 4, '0);
        chk("redirect_no_push", 64'(count), 64'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, m_pc + 4, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, m_pc + 4, '0);
        chk("refill_count", 64'(count), 64'h2);
        chk("refill_head",  64'(pc),    64'h100);

        // Freeze drains the queue without fetching
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, $urandom, m_pc + 4, '0);
        chk("freeze_valid", 64'(instr_valid), 64'h0);
        chk("freeze_addr",  64'(imemaddr),    64'h108);
        step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, m_pc + 4, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, m_pc + 4, '0);
        chk("resume_count", 64'(count), 64'h1);
        chk("resume_head",  64'(pc),    64'h108);
        step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, m_pc + 4, '0);
        chk("pre_rst_count", 64'(count), 64'h2);

        // Asynchronous reset mid-stream, then restart at RESET_PC
        async_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, m_pc + 4, '0);
        chk("restart_head", 64'(pc), 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 4) == 0),
                 $urandom,
                 ($urandom_range(0, 3) == 0) ? {$urandom, 2'b00} : m_pc + 4,
                 {$urandom, 2'b00});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, setting the width of instruction words and addresses.
REQ-002 The block SHALL have parameter DEPTH, default 4, setting the number of fetch-queue entries; DEPTH is a power of two and at least 2.
REQ-003 The block SHALL have parameter RESET_PC, default 0, setting the fetch PC after reset.
REQ-004 The block SHALL have the following ports (name  direction  width  meaning):
  CLK  in  1  single clock, rising-edge.
  nRST  in  1  reset, asynchronous, active-low.
  imemREN  out  1  instruction memory read enable.
  imemaddr  out  WORD_W  fetch address, equal to the fetch PC register.
  ihit  in  1  imemload valid for imemaddr this cycle.
  imemload  in  WORD_W  instruction data.
  pc_prediction  in  WORD_W  predicted next PC for the current imemaddr.
  misprediction  in  1  flush request from backend.
  correct_pc  in  WORD_W  redirect target, valid with misprediction.
  freeze  in  1  suspend new fetches.
  instr_valid  out  1  head entry valid.
  instr  out  WORD_W  head instruction.
  pc  out  WORD_W  head PC.
  deq_ready  in  1  consumer takes head this cycle.
  count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-005 The block SHALL implement FSM states RUN, HOLD and REDIRECT.
REQ-006 In RUN, the block SHALL drive imemREN=1 when full=0, freeze=0 and misprediction=0; otherwise it SHALL drive imemREN=0.
REQ-007 In HOLD and REDIRECT, the block SHALL drive imemREN=0; imemREN SHALL NOT depend combinationally on deq_ready.
REQ-008 A push SHALL occur when imemREN=1 and ihit=1: the entry {imemaddr, imemload} is written at the tail and the fetch PC loads pc_prediction.
REQ-009 Without a push or misprediction, the fetch PC SHALL hold its value.
REQ-010 A pop SHALL occur when instr_valid=1, deq_ready=1 and misprediction=0; the head pointer advances.
REQ-011 instr_valid SHALL equal (count!=0); instr and pc SHALL show the head entry, and SHALL be 0 when the queue is empty.
REQ-012 On simultaneous push and pop, count SHALL be unchanged and FIFO order SHALL be preserved.
REQ-013 A pop on an empty queue SHALL be ignored.
REQ-014 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-015 full SHALL equal (count==DEPTH); count SHALL never exceed DEPTH.
REQ-016 misprediction=1 SHALL take priority over all other events in any state: no push, no pop, count<=0, pointers<=0, fetch PC<=correct_pc, next state REDIRECT.
REQ-017 Any ihit coincident with misprediction SHALL be discarded.
REQ-018 REDIRECT SHALL last exactly one cycle, then go to HOLD if freeze=1, else RUN.
REQ-019 RUN SHALL go to HOLD when freeze=1; HOLD SHALL go to RUN when freeze=0.
REQ-020 Pops SHALL continue in HOLD and REDIRECT, so the queue drains while frozen.
REQ-021 Fetch latency SHALL be: an ihit in cycle N makes that instruction visible at the head in cycle N+1 if the queue was empty.
REQ-022 The block SHALL fetch a single instruction per cycle.

Reset
REQ-023 While nRST=0, the block SHALL asynchronously set state=RUN, fetch PC=RESET_PC, pointers=0, count=0, instr_valid=0, instr=0, pc=0.
REQ-024 While nRST=0, the block SHALL drive imemaddr=RESET_PC and imemREN=0.
REQ-025 Reset asserted mid-operation SHALL discard all queued entries; after release, the first request SHALL be to RESET_PC.

Verification
REQ-026 Reset/start: pulse nRST low, release with freeze=0 -> cycle after release imemREN=1, imemaddr=0x0, count=0.
REQ-027 Fill: ihit=1 each cycle, pc_prediction=imemaddr+4, deq_ready=0 -> entries PC 0x0,0x4,0x8,0xC; count=4; imemREN=0; imemaddr holds 0x10.
REQ-028 Wrap/streaming: deq_ready=1 with continuous ihit for 10 cycles -> count steady, pops in order 0x0..0x24, pointers wrap twice, no loss or duplication.
REQ-029 Flush: count=3, misprediction=1 with correct_pc=0x100 and ihit=1 in the same cycle -> next cycle count=0, instr_valid=0, imemREN=0 (REDIRECT); following cycle imemaddr=0x100, imemREN=1.
REQ-030 Freeze: freeze=1 with count=2, deq_ready=1 -> imemREN=0, two pops then instr_valid=0, fetch PC unchanged; freeze=0 -> fetching resumes at the same address.
REQ-031 Async reset mid-stream: drop nRST between clock edges with count=2 -> count=0 and instr_valid=0 immediately, before the next edge.
